layer_weight_loader: RTL and testbench
======================================

# layer_weight_loader

- Initiator side of the neuron weight/bias configuration bus for one fully connected layer.
- Accepts a flat word stream from the host over a valid/ready handshake.
- Broadcasts each word to all neurons of the layer on `weightValid`/`biasValid`, `weightValue`/`biasValue`, and `config_layer_num`/`config_neuron_num`. Each neuron captures only the words addressed to it.
- Sits between the host configuration FIFO and the neuron array. It replaces direct host driving of the configuration bus.

## Interface
Parameters:
- `layerNo`, 1, layer index driven on `config_layer_num`.
- `numNeurons`, 30, neurons in the layer.
- `numWeight`, 784, weights per neuron.
- `neuronBase`, 0, `config_neuron_num` value of the first neuron.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle request to load the whole layer.
- `s_data` in 32: host word.
- `s_valid` in 1: host word valid.
- `s_ready` out 1: loader accepts word.
- `weightValid` out 1: `weightValue` is a weight for the addressed neuron.
- `biasValid` out 1: `biasValue` is the bias for the addressed neuron.
- `weightValue` out 32: weight word.
- `biasValue` out 32: bias word.
- `config_layer_num` out 32: layer address.
- `config_neuron_num` out 32: neuron address.
- `busy` out 1: load in progress.
- `done` out 1: one-cycle pulse when the last bias has been issued.

## Operation
- Host stream order: for neuron k = 0..numNeurons-1, numWeight weights, then 1 bias. Total numNeurons*(numWeight+1) words.
- States:
  - IDLE: `s_ready`=0. `start` moves to WEIGHT with neuron counter n=0 and weight counter w=0.
  - WEIGHT: `s_ready`=1. Each accepted word (`s_valid`&`s_ready`) increments w. The accept that makes w reach numWeight clears w and moves to BIAS.
  - BIAS: `s_ready`=1.
    - One accepted word increments n.
    - If n was numNeurons-1, move to DONE.
    - Otherwise return to WEIGHT.
  - DONE: one cycle, `done`=1, then IDLE.
- `s_ready` is a combinational decode of the state: high only in WEIGHT and BIAS.
- The neuron array has no backpressure. Pacing is set entirely by `s_valid`. Gaps in `s_valid` produce gaps in `weightValid`.
- `config_layer_num` = layerNo constant after reset.
- `config_neuron_num` = neuronBase+n of the accepted word. It is registered with the valid strobe and held until the next strobe.
- `weightValue`/`biasValue` hold their last value when the matching valid is low.
- `start` in any state other than IDLE is ignored.
- `busy` = 1 in WEIGHT and BIAS.
- Counters:
  - w is $clog2(numWeight+1) bits.
  - n is $clog2(numNeurons+1) bits.
  - No wrap: terminal counts are compared exactly.
- Neurons increment their write address from all-ones on reset. A second load without an intervening `rst` is therefore not supported; `start` after DONE reloads from word 0 only after `rst`.

## Timing
- Reset values: state IDLE, `s_ready`=0, `weightValid`=0, `biasValid`=0, `weightValue`=0, `biasValue`=0, `config_layer_num`=layerNo, `config_neuron_num`=neuronBase, `busy`=0, `done`=0.
- `start` sampled at cycle t: `busy`=1 and `s_ready`=1 at t+1.
- Word accepted at cycle t:
  - Weight: `weightValid`=1 at t+1 with `weightValue`=`s_data`(t) and `config_neuron_num`=neuronBase+n(t).
  - Bias: same, on `biasValid`/`biasValue`.
- Strobes are single-cycle per accepted word. `weightValid` and `biasValid` are never high together.
- Final bias accepted at t:
  - `biasValid`=1 at t+1.
  - `done`=1 at t+1 (DONE state).
  - `busy`=0 and `s_ready`=0 from t+1.
  - IDLE at t+2.
- Back-to-back accepts give one strobe per cycle. There is no bubble between the last weight and the bias, or between a bias and the next neuron's first weight.
- `rst` mid-load: the next cycle is in the reset state. Words in flight are dropped and there is no strobe on the cycle after `rst`.
- `s_valid` high in IDLE or DONE: the word is not accepted and the host holds it.

## Test plan
- Params numNeurons=2, numWeight=4, neuronBase=0, layerNo=1. `start`, then 10 back-to-back words 0x10..0x19:
  - `weightValid` on 0x10–0x13 with neuron 0.
  - `biasValid` on 0x14 with neuron 0.
  - Weights 0x15–0x18 with neuron 1, then bias 0x19 with neuron 1.
  - `done` coincides with the 0x19 strobe.
  - 10 strobes over 10 consecutive cycles.
- Same stream with `s_valid` low on alternate cycles: identical strobe sequence, each strobe 1 cycle after its accept, and `busy` high throughout.
- `start` pulsed again mid-load after word 3: no effect, and the strobe sequence is unchanged.
- `rst` asserted after word 6 accepted:
  - All outputs return to reset values on the next cycle.
  - `s_ready`=0 and no further strobes.
  - A fresh `start` loads neuron 0 from word 0.
- `s_valid`=1 with data 0xAA while IDLE for 5 cycles: `s_ready`=0 and no strobes.
- neuronBase=23, numNeurons=1, numWeight=3: `config_neuron_num`=23 on all 4 strobes, and `config_layer_num`=1 throughout.

Source files
------------

// File: rtl/layer_weight_loader.sv
// Configuration-bus initiator for one fully connected layer: takes the host word stream
// (weights then bias, neuron by neuron) and broadcasts each word as an addressed strobe.
module layer_weight_loader #(
    parameter int layerNo    = 1,
    parameter int numNeurons = 30,
    parameter int numWeight  = 784,
    parameter int neuronBase = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic        weightValid,
    output logic        biasValid,
    output logic [31:0] weightValue,
    output logic [31:0] biasValue,
    output logic [31:0] config_layer_num,
    output logic [31:0] config_neuron_num,
    output logic        busy,
    output logic        done
);

    localparam int WW = $clog2(numWeight + 1);
    localparam int NW = $clog2(numNeurons + 1);
    localparam logic [WW-1:0] W_LAST = WW'(numWeight - 1);
    localparam logic [NW-1:0] N_LAST = NW'(numNeurons - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WEIGHT = 2'd1,
        ST_BIAS   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [WW-1:0] w_q, w_d;
    logic [NW-1:0] n_q, n_d;
    logic          weight_valid_q, weight_valid_d;
    logic          bias_valid_q, bias_valid_d;
    logic [31:0]   weight_value_q, weight_value_d;
    logic [31:0]   bias_value_q, bias_value_d;
    logic [31:0]   neuron_num_q, neuron_num_d;
    logic          accept_s;
    logic [31:0]   addr_s;

    assign s_ready = (state_q == ST_WEIGHT) || (state_q == ST_BIAS);
    assign busy    = s_ready;
    assign done    = (state_q == ST_DONE);
    assign accept_s = s_valid && s_ready;
    assign addr_s   = 32'(neuronBase) + 32'(n_q);

    assign weightValid       = weight_valid_q;
    assign biasValid         = bias_valid_q;
    assign weightValue       = weight_value_q;
    assign biasValue         = bias_value_q;
    assign config_neuron_num = neuron_num_q;
    assign config_layer_num  = 32'(layerNo);

    // State, counters and the registered configuration bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            w_q            <= '0;
            n_q            <= '0;
            weight_valid_q <= 1'b0;
            bias_valid_q   <= 1'b0;
            weight_value_q <= 32'd0;
            bias_value_q   <= 32'd0;
            neuron_num_q   <= 32'(neuronBase);
        end else begin
            state_q        <= state_d;
            w_q            <= w_d;
            n_q            <= n_d;
            weight_valid_q <= weight_valid_d;
            bias_valid_q   <= bias_valid_d;
            weight_value_q <= weight_value_d;
            bias_value_q   <= bias_value_d;
            neuron_num_q   <= neuron_num_d;
        end
    end

    // Next-state decode; strobes default low, values and address hold between strobes.
    always_comb begin
        state_d        = state_q;
        w_d            = w_q;
        n_d            = n_q;
        weight_valid_d = 1'b0;
        bias_valid_d   = 1'b0;
        weight_value_d = weight_value_q;
        bias_value_d   = bias_value_q;
        neuron_num_d   = neuron_num_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_WEIGHT;
                    w_d     = '0;
                    n_d     = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WEIGHT: begin
                if (accept_s) begin
                    weight_valid_d = 1'b1;
                    weight_value_d = s_data;
                    neuron_num_d   = addr_s;
                    if (w_q == W_LAST) begin
                        w_d     = '0;
                        state_d = ST_BIAS;
                    end else begin
                        w_d = w_q + WW'(1);
                    end
                end else begin
                    state_d = ST_WEIGHT;
                end
            end
            ST_BIAS: begin
                if (accept_s) begin
                    bias_valid_d = 1'b1;
                    bias_value_d = s_data;
                    neuron_num_d = addr_s;
                    n_d          = n_q + NW'(1);
                    if (n_q == N_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WEIGHT;
                    end
                end else begin
                    state_d = ST_BIAS;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_layer_weight_loader.sv
// Directed bench: a 2-neuron x 4-weight loader (stream 0x10..0x19) and a
// 1-neuron x 3-weight loader at neuron base 23.
module tb_layer_weight_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a, s_valid_a, s_ready_a, wv_a, bv_a, busy_a, done_a;
    logic [31:0] s_data_a, wval_a, bval_a, layer_a, neuron_a;
    logic        start_b, s_valid_b, s_ready_b, wv_b, bv_b, busy_b, done_b;
    logic [31:0] s_data_b, wval_b, bval_b, layer_b, neuron_b;

    int errors = 0;
    int checks = 0;
    logic [31:0] last_w, last_b, last_n;

    always #5 clk = ~clk;

    layer_weight_loader #(.layerNo(1), .numNeurons(2), .numWeight(4), .neuronBase(0)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .s_data(s_data_a), .s_valid(s_valid_a),
        .s_ready(s_ready_a), .weightValid(wv_a), .biasValid(bv_a), .weightValue(wval_a),
        .biasValue(bval_a), .config_layer_num(layer_a), .config_neuron_num(neuron_a),
        .busy(busy_a), .done(done_a)
    );

    layer_weight_loader #(.layerNo(1), .numNeurons(1), .numWeight(3), .neuronBase(23)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .s_data(s_data_b), .s_valid(s_valid_b),
        .s_ready(s_ready_b), .weightValid(wv_b), .biasValid(bv_b), .weightValue(wval_b),
        .biasValue(bval_b), .config_layer_num(layer_b), .config_neuron_num(neuron_b),
        .busy(busy_b), .done(done_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full output check of dut_a against expected strobes and held values.
    task automatic exp_a(input string tag, input logic wv, input logic bv, input logic dn, input logic bs);
        chk({tag, ".weightValid"}, 32'(wv_a), 32'(wv));
        chk({tag, ".biasValid"}, 32'(bv_a), 32'(bv));
        chk({tag, ".weightValue"}, wval_a, last_w);
        chk({tag, ".biasValue"}, bval_a, last_b);
        chk({tag, ".neuron"}, neuron_a, last_n);
        chk({tag, ".layer"}, layer_a, 32'd1);
        chk({tag, ".done"}, 32'(done_a), 32'(dn));
        chk({tag, ".busy"}, 32'(busy_a), 32'(bs));
        chk({tag, ".s_ready"}, 32'(s_ready_a), 32'(bs));
    endtask

    // Word k of the 2x(4+1) stream is 0x10+k; every fifth word is a bias.
    task automatic word_a(input string tag, input int k);
        last_n = 32'(k / 5);
        if (k % 5 == 4) begin
            last_b = 32'h10 + 32'(k);
            exp_a(tag, 1'b0, 1'b1, k == 9, k != 9);
        end else begin
            last_w = 32'h10 + 32'(k);
            exp_a(tag, 1'b1, 1'b0, 1'b0, 1'b1);
        end
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1; start_a = 1'b0; s_valid_a = 1'b0; start_b = 1'b0; s_valid_b = 1'b0;
        s_data_a = 32'd0; s_data_b = 32'd0;
        tick();
        last_w = 32'd0; last_b = 32'd0; last_n = 32'd0;
        exp_a(tag, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    // One load of dut_a; gap inserts an idle s_valid cycle after each word,
    // restart_at pulses start alongside a word, abort_after asserts rst after that word.
    task automatic run_load(input string tag, input bit gap, input int restart_at, input int abort_after);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        exp_a({tag, ".started"}, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 10; k++) begin
            s_valid_a = 1'b1;
            s_data_a  = 32'h10 + 32'(k);
            if (k == restart_at) start_a = 1'b1;
            tick();
            start_a   = 1'b0;
            s_valid_a = 1'b0;
            word_a($sformatf("%s.w%0d", tag, k), k);
            if (k == abort_after) begin
                rst = 1'b1; s_valid_a = 1'b1; s_data_a = 32'h10 + 32'(k + 1);
                tick();
                last_w = 32'd0; last_b = 32'd0; last_n = 32'd0;
                exp_a({tag, ".rst"}, 1'b0, 1'b0, 1'b0, 1'b0);
                rst = 1'b0;
                tick();
                exp_a({tag, ".postrst"}, 1'b0, 1'b0, 1'b0, 1'b0);
                s_valid_a = 1'b0;
                return;
            end
            if (gap && k != 9) begin
                tick();
                exp_a($sformatf("%s.gap%0d", tag, k), 1'b0, 1'b0, 1'b0, 1'b1);
            end
        end
        tick();
        exp_a({tag, ".idle"}, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        do_reset("reset");
        chk("b.reset.neuron", neuron_b, 32'd23);
        chk("b.reset.layer", layer_b, 32'd1);
        chk("b.reset.busy", 32'(busy_b), 32'd0);

        s_valid_a = 1'b1; s_data_a = 32'hAA;
        for (int i = 0; i < 5; i++) begin
            tick();
            exp_a($sformatf("idle_aa%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        s_valid_a = 1'b0;

        run_load("b2b", 1'b0, -1, -1);
        do_reset("rst1");
        run_load("gap", 1'b1, -1, -1);
        do_reset("rst2");
        run_load("restart", 1'b0, 3, -1);
        do_reset("rst3");
        run_load("abort", 1'b0, -1, 6);
        run_load("reload", 1'b0, -1, -1);

        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        chk("b.started.busy", 32'(busy_b), 32'd1);
        for (int k = 0; k < 4; k++) begin
            s_valid_b = 1'b1;
            s_data_b  = 32'h30 + 32'(k);
            tick();
            s_valid_b = 1'b0;
            chk($sformatf("b.w%0d.weightValid", k), 32'(wv_b), (k < 3) ? 32'd1 : 32'd0);
            chk($sformatf("b.w%0d.biasValid", k), 32'(bv_b), (k == 3) ? 32'd1 : 32'd0);
            chk($sformatf("b.w%0d.value", k), (k < 3) ? wval_b : bval_b, 32'h30 + 32'(k));
            chk($sformatf("b.w%0d.neuron", k), neuron_b, 32'd23);
            chk($sformatf("b.w%0d.layer", k), layer_b, 32'd1);
            chk($sformatf("b.w%0d.done", k), 32'(done_b), (k == 3) ? 32'd1 : 32'd0);
        end
        tick();
        chk("b.idle.done", 32'(done_b), 32'd0);
        chk("b.idle.busy", 32'(busy_b), 32'd0);
        chk("b.idle.bv", 32'(bv_b), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
